// File: rtl/merge_out_writer_pkg.sv
// Shared constants, state encoding and helpers for the merge output writer.
package merge_out_writer_pkg;

    localparam int REC_W      = 32;
    localparam int P          = 8;
    localparam int TUP_W      = P * REC_W;
    localparam int LINE_W     = 2 * TUP_W;
    localparam int LINE_BYTES = 64;

    localparam logic [REC_W-1:0] PAD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Upper half used to complete a lone half line at the end of a flushed pass.
    function automatic logic [TUP_W-1:0] pad_tuple();
        return {P{PAD}};
    endfunction

endpackage

// File: rtl/merge_out_writer_fifo.sv
// Synchronous tuple FIFO. The head entry is always presented on o_data;
// a push is only visible at the head on the following cycle.
module out_tuple_fifo #(
    parameter int W     = 256,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    // Ignore a push while full or a pop while empty so the pointers never corrupt.
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/merge_out_writer.sv
// Sink behind the merger-tree root: buffers tuples, pairs them into 512-bit
// lines and writes them to consecutive line addresses, then reports completion.
//
// Handshakes: the input side transfers a tuple on a cycle where i_write and
// o_ready are both 1 (o_ready never looks at i_write); the memory side holds
// o_mem_valid, o_mem_addr and o_mem_data stable until a cycle where
// i_mem_ready is 1, which completes the transfer.
module merge_out_writer
    import merge_out_writer_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [31:0]       i_num_lines,
    input  logic              i_flush,
    input  logic              i_write,
    input  logic [TUP_W-1:0]  i_data,
    output logic              o_ready,
    output logic              o_mem_valid,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [LINE_W-1:0] o_mem_data,
    input  logic              i_mem_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_lines_written,
    output logic              o_overflow,
    output state_e            o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        num_lines_q, num_lines_d;
    logic [31:0]        lines_q, lines_d;
    logic [TUP_W-1:0]   half_q, half_d;
    logic               half_vld_q, half_vld_d;
    logic               mem_valid_q, mem_valid_d;
    logic [LINE_W-1:0]  mem_data_q, mem_data_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic               fifo_push, fifo_pop;
    logic [TUP_W-1:0]   fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_full, fifo_empty;

    logic               busy, can_issue, mem_hs, excess;
    logic [33:0]        tuples_committed;

    out_tuple_fifo #(
        .W     (TUP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_data  (i_data),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign busy      = (state_q == RUN) || (state_q == FLUSH);
    assign o_ready   = (state_q == RUN) && !fifo_full;
    assign can_issue = !mem_valid_q || i_mem_ready;
    assign mem_hs    = mem_valid_q && i_mem_ready;

    // Tuples already written or in flight; once they fill the pass, further tuples are excess.
    assign tuples_committed = {1'b0, lines_q, 1'b0} + 34'(fifo_count)
                            + 34'(half_vld_q) + {32'd0, mem_valid_q, 1'b0};
    assign excess    = tuples_committed >= {1'b0, num_lines_q, 1'b0};
    assign fifo_push = i_write && o_ready && !excess;

    // Next-state logic: packing, memory handshake, overflow tracking and pass control.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        num_lines_d = num_lines_q;
        lines_d     = lines_q;
        half_d      = half_q;
        half_vld_d  = half_vld_q;
        mem_valid_d = mem_valid_q;
        mem_data_d  = mem_data_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        fifo_pop    = 1'b0;

        if (mem_hs) begin
            mem_valid_d = 1'b0;
            addr_d      = addr_q + ADDR_W'(LINE_BYTES);
            lines_d     = lines_q + 32'd1;
        end

        if (busy) begin
            if (!fifo_empty) begin
                if (!half_vld_q) begin
                    fifo_pop   = 1'b1;
                    half_d     = fifo_head;
                    half_vld_d = 1'b1;
                end else if (can_issue) begin
                    fifo_pop    = 1'b1;
                    half_vld_d  = 1'b0;
                    mem_data_d  = {fifo_head, half_q};
                    mem_valid_d = 1'b1;
                end
            end else if ((state_q == FLUSH) && half_vld_q && can_issue) begin
                // No partner tuple will arrive: complete the line with pad records.
                half_vld_d  = 1'b0;
                mem_data_d  = {pad_tuple(), half_q};
                mem_valid_d = 1'b1;
            end
        end

        if (i_write && (!o_ready || excess)) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_d     = RUN;
                    addr_d      = i_base_addr;
                    num_lines_d = i_num_lines;
                    lines_d     = 32'd0;
                    overflow_d  = 1'b0;
                end
            end
            RUN: begin
                // Use the post-handshake count so the final line and a flush can coincide.
                if (lines_d == num_lines_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (i_flush) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (fifo_empty && !half_vld_q && !mem_valid_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register all state; reset clears outputs and abandons any outstanding request.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            num_lines_q <= '0;
            lines_q     <= '0;
            half_q      <= '0;
            half_vld_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            num_lines_q <= num_lines_d;
            lines_q     <= lines_d;
            half_q      <= half_d;
            half_vld_q  <= half_vld_d;
            mem_valid_q <= mem_valid_d;
            mem_data_q  <= mem_data_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
        end
    end

    assign o_mem_valid     = mem_valid_q;
    assign o_mem_addr      = addr_q;
    assign o_mem_data      = mem_data_q;
    assign o_busy          = busy;
    assign o_done          = done_q;
    assign o_lines_written = lines_q;
    assign o_overflow      = overflow_q;
    assign o_dbg_state     = state_q;

endmodule
